// File: rtl/aes_round_sequencer_pkg.sv
// Shared encodings for the AES round sequencer: key-size modes, phases,
// and the round-count lookup used when a run is started.
package aes_seq_pkg;

    localparam logic [1:0] MODE_128 = 2'd0;
    localparam logic [1:0] MODE_192 = 2'd1;
    localparam logic [1:0] MODE_256 = 2'd2;
    localparam logic [1:0] MODE_ILL = 2'd3;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_ENC  = 2'd1;
    localparam logic [1:0] PH_DEC  = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

    // Round count for a key-size mode; the illegal mode maps to zero rounds.
    function automatic int nr_of(input logic [1:0] mode,
                                 input int n128 = NR_128_DEF,
                                 input int n192 = NR_192_DEF,
                                 input int n256 = NR_256_DEF);
        case (mode)
            MODE_128: return n128;
            MODE_192: return n192;
            MODE_256: return n256;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Control/data bundle between the front end / datapath and the sequencer.
// master = front end + external datapath, slave = sequencer.
interface aes_round_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 5
);
    logic [1:0]        mode_i;
    logic              start_i;
    logic              step_i;
    logic              abort_i;
    logic [DATA_W-1:0] pt_i;
    logic [DATA_W-1:0] enc_blk_i;
    logic [DATA_W-1:0] dec_blk_i;
    logic [1:0]        mode_o;
    logic [1:0]        phase_o;
    logic [CNT_W-1:0]  round_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              done_o;
    logic              match_o;
    logic              err_o;

    modport master (
        output mode_i, start_i, step_i, abort_i, pt_i, enc_blk_i, dec_blk_i,
        input  mode_o, phase_o, round_o, data_o, busy_o, done_o, match_o, err_o
    );

    modport slave (
        input  mode_i, start_i, step_i, abort_i, pt_i, enc_blk_i, dec_blk_i,
        output mode_o, phase_o, round_o, data_o, busy_o, done_o, match_o, err_o
    );
endinterface

// File: rtl/aes_round_sequencer_step_gen.sv
// Step pulse generator: rising-edge detector on the synchronised button, or,
// when AES_SEQ_AUTO_STEP_EN is defined, a free-running divider that fires one
// pulse every AUTO_DIV clocks while the sequencer is busy.
module aes_step_gen #(
    parameter int AUTO_DIV = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic step_i,
    input  logic busy_i,
    input  logic reload_i,
    output logic step_o
);
`ifdef AES_SEQ_AUTO_STEP_EN
    localparam int DIV_W = $clog2(AUTO_DIV + 1);

    logic [DIV_W-1:0] div_cnt;
    wire              unused_step = step_i;

    // Count down while busy; reload on run start/abort and after each pulse.
    always_ff @(posedge clk) begin
        if (!reset_n || reload_i) begin
            div_cnt <= DIV_W'(AUTO_DIV - 1);
        end else if (busy_i) begin
            if (div_cnt == '0) div_cnt <= DIV_W'(AUTO_DIV - 1);
            else               div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    assign step_o = busy_i && (div_cnt == '0);
`else
    localparam int unused_div = AUTO_DIV;

    logic step_q;
    wire  unused_ctl = busy_i ^ reload_i;

    // Remember last button level so a held button yields a single pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) step_q <= 1'b0;
        else          step_q <= step_i;
    end

    assign step_o = step_i & ~step_q;
`endif
endmodule

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: walks one block through encryption then decryption,
// one round per step, presenting the round index to the external round-output
// muxes and capturing each round result one clock later.
// Optional build macro: AES_SEQ_AUTO_STEP_EN (internal timed stepping).
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int NR_128   = 10,
    parameter int NR_192   = 12,
    parameter int NR_256   = 14,
    parameter int CNT_W    = 5,
    parameter int AUTO_DIV = 50000000
) (
    input logic                  clk,
    input logic                  reset_n,
    aes_round_sequencer_if.slave bus
);
    logic [1:0]        phase;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  round;
    logic [CNT_W-1:0]  nr;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] pt_q;
    logic              pend;
    logic              match_q;
    logic              err_q;
    logic              busy;
    logic              step_pulse;
    logic              start_ok;

    assign busy     = (phase == PH_ENC) || (phase == PH_DEC);
    assign start_ok = bus.start_i && !bus.abort_i && !busy && (bus.mode_i != MODE_ILL);

    aes_step_gen #(.AUTO_DIV(AUTO_DIV)) u_step_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .step_i   (bus.step_i),
        .busy_i   (busy),
        .reload_i (start_ok || (bus.abort_i && busy)),
        .step_o   (step_pulse)
    );

    // Sequencer FSM: abort > start > capture > step; a step that lands while a
    // capture is pending is dropped because the capture branch wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase   <= PH_IDLE;
            mode_q  <= MODE_128;
            round   <= '0;
            data_q  <= '0;
            pend    <= 1'b0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.abort_i) begin
            if (busy) begin
                phase <= PH_IDLE;
                round <= '0;
                pend  <= 1'b0;
            end
        end else if (bus.start_i && !busy) begin
            if (bus.mode_i == MODE_ILL) begin
                err_q <= 1'b1;
            end else begin
                mode_q  <= bus.mode_i;
                nr      <= CNT_W'(nr_of(bus.mode_i, NR_128, NR_192, NR_256));
                pt_q    <= bus.pt_i;
                data_q  <= bus.pt_i;
                round   <= '0;
                pend    <= 1'b0;
                match_q <= 1'b0;
                err_q   <= 1'b0;
                phase   <= PH_ENC;
            end
        end else if (pend) begin
            pend <= 1'b0;
            if (phase == PH_ENC) begin
                data_q <= bus.enc_blk_i;
            end else begin
                data_q <= bus.dec_blk_i;
                if (round == nr) begin
                    phase   <= PH_DONE;
                    match_q <= (bus.dec_blk_i == pt_q);
                end
            end
        end else if (step_pulse && busy) begin
            if (round < nr) begin
                round <= round + CNT_W'(1);
                pend  <= 1'b1;
            end else if (phase == PH_ENC) begin
                phase <= PH_DEC;
                round <= CNT_W'(1);
                pend  <= 1'b1;
            end
        end
    end

    assign bus.mode_o  = mode_q;
    assign bus.phase_o = phase;
    assign bus.round_o = round;
    assign bus.data_o  = data_q;
    assign bus.busy_o  = busy;
    assign bus.done_o  = (phase == PH_DONE);
    assign bus.match_o = match_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer. A behavioural stand-in for the
// external round-output muxes feeds enc/dec blocks from round_o/mode_o;
// expected captures are queued at each step and popped when data_o lands.
module tb_aes_round_sequencer;
    import aes_seq_pkg::*;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic corrupt = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] sb[$];

    logic [1:0] m_phase;
    logic [1:0] m_mode;
    int         m_round;
    int         m_nr;
    logic       m_match;

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.DATA_W(128), .CNT_W(5)) bus ();

    aes_round_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic int nr_m(input logic [1:0] md);
        case (md)
            2'd0:    return 10;
            2'd1:    return 12;
            2'd2:    return 14;
            default: return 0;
        endcase
    endfunction

    function automatic logic [127:0] ct_m(input logic [1:0] md);
        case (md)
            2'd0:    return CT128;
            2'd1:    return CT192;
            default: return CT256;
        endcase
    endfunction

    // Stand-in encrypt mux: final round gives the reference ciphertext.
    function automatic logic [127:0] enc_f(input logic [1:0] md, input int r);
        logic [31:0] w;
        if (r == nr_m(md)) return ct_m(md);
        w = 32'(r) * 32'h01030507 + 32'(md) * 32'h00010000;
        return PT ^ {4{w}};
    endfunction

    // Stand-in decrypt mux: final round recovers the plaintext (unless corrupted).
    function automatic logic [127:0] dec_f(input logic [1:0] md, input int r, input logic bad);
        logic [31:0] w;
        if (r == nr_m(md)) return bad ? (PT ^ 128'h1) : PT;
        w = 32'(r) * 32'h00ff00ff + 32'(md) * 32'h11000000;
        return ct_m(md) ^ {4{w}};
    endfunction

    assign bus.enc_blk_i = enc_f(bus.mode_o, int'(bus.round_o));
    assign bus.dec_blk_i = dec_f(bus.mode_o, int'(bus.round_o), corrupt);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] md);
        bus.mode_i  = md;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        m_phase = PH_ENC;
        m_mode  = md;
        m_round = 0;
        m_nr    = nr_m(md);
        m_match = 1'b0;
        chk("start_phase", 128'(bus.phase_o), 128'(PH_ENC));
        chk("start_data", bus.data_o, PT);
        chk("start_round", 128'(bus.round_o), 128'd0);
    endtask

    task automatic do_step(input bit toggle);
        logic [127:0] e;
        if (m_round < m_nr) begin
            m_round++;
        end else begin
            m_phase = PH_DEC;
            m_round = 1;
        end
        e = (m_phase == PH_ENC) ? enc_f(m_mode, m_round) : dec_f(m_mode, m_round, corrupt);
        if (m_phase == PH_DEC && m_round == m_nr) begin
            m_phase = PH_DONE;
            m_match = !corrupt;
        end
        sb.push_back(e);
        bus.step_i = 1'b1;
        if (toggle) bus.mode_i = bus.mode_i ^ 2'b10;
        tick();
        bus.step_i = 1'b0;
        tick();
        if (sb.size() == 0) begin
            chk("sb_empty", 128'd1, 128'd0);
        end else begin
            chk("step_data", bus.data_o, sb.pop_front());
        end
        chk("step_round", 128'(bus.round_o), 128'(m_round));
        chk("step_phase", 128'(bus.phase_o), 128'(m_phase));
    endtask

    task automatic run_full(input logic [1:0] md, input logic bad);
        corrupt = bad;
        start_run(md);
        for (int i = 0; i < nr_m(md); i++) do_step(1'b0);
        chk("enc_final", bus.data_o, ct_m(md));
        for (int i = 0; i < nr_m(md); i++) do_step(1'b0);
        chk("done", 128'(bus.done_o), 128'd1);
        chk("busy_end", 128'(bus.busy_o), 128'd0);
        chk("match", 128'(bus.match_o), 128'(m_match));
        corrupt = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, 128'(bus.phase_o), 128'd0);
        chk({tag, "_round"}, 128'(bus.round_o), 128'd0);
        chk({tag, "_data"},  bus.data_o, 128'd0);
        chk({tag, "_mode"},  128'(bus.mode_o), 128'd0);
        chk({tag, "_flags"}, 128'({bus.busy_o, bus.done_o, bus.match_o, bus.err_o}), 128'd0);
    endtask

    initial begin
        bus.mode_i  = 2'd0;
        bus.start_i = 1'b0;
        bus.step_i  = 1'b0;
        bus.abort_i = 1'b0;
        bus.pt_i    = PT;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // AES-128 loopback
        run_full(2'd0, 1'b0);
        chk("done_data", bus.data_o, PT);

        // Step in DONE is ignored
        bus.step_i = 1'b1; tick(); bus.step_i = 1'b0; tick();
        chk("done_step_round", 128'(bus.round_o), 128'd10);
        chk("done_step_phase", 128'(bus.phase_o), 128'(PH_DONE));

        // Held button: one round, data two clocks after edge
        start_run(2'd0);
        bus.step_i = 1'b1;
        tick();
        chk("held_round1", 128'(bus.round_o), 128'd1);
        chk("held_data_early", bus.data_o, PT);
        tick();
        chk("held_data", bus.data_o, enc_f(2'd0, 1));
        repeat (98) tick();
        chk("held_round_end", 128'(bus.round_o), 128'd1);
        bus.step_i = 1'b0;
        tick();
        m_round = 1;
        for (int i = 0; i < 4; i++) do_step(1'b0);

        // Abort at ENC round 5
        bus.abort_i = 1'b1; tick(); bus.abort_i = 1'b0;
        chk("abort_phase", 128'(bus.phase_o), 128'(PH_IDLE));
        chk("abort_round", 128'(bus.round_o), 128'd0);
        chk("abort_data", bus.data_o, enc_f(2'd0, 5));

        // Illegal mode then legal start
        bus.mode_i = 2'd3; bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        chk("ill_err", 128'(bus.err_o), 128'd1);
        chk("ill_phase", 128'(bus.phase_o), 128'(PH_IDLE));
        start_run(2'd0);
        chk("legal_err", 128'(bus.err_o), 128'd0);

        // mode_i toggled while busy, then reset mid-run
        for (int i = 0; i < 5; i++) do_step(1'b1);
        chk("toggle_mode", 128'(bus.mode_o), 128'd0);
        reset_n = 1'b0;
        tick();
        chk_all_zero("midreset");
        reset_n = 1'b1;
        bus.mode_i = 2'd0;
        tick();

        // AES-192 with a start pulse while busy
        start_run(2'd1);
        for (int i = 0; i < 3; i++) do_step(1'b0);
        bus.mode_i = 2'd2; bus.start_i = 1'b1; tick(); bus.start_i = 1'b0; tick();
        chk("busy_start_round", 128'(bus.round_o), 128'd3);
        chk("busy_start_mode", 128'(bus.mode_o), 128'd1);
        for (int i = 0; i < 9; i++) do_step(1'b0);
        chk("enc192_final", bus.data_o, CT192);
        for (int i = 0; i < 12; i++) do_step(1'b0);
        chk("done192", 128'(bus.done_o), 128'd1);
        chk("match192", 128'(bus.match_o), 128'd1);

        // AES-256 clean, then with corrupted final decrypt
        run_full(2'd2, 1'b0);
        run_full(2'd2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
